// File: rtl/stream_acc_pkg.sv
// Shared types and saturation-limit helpers for the streaming accumulator.
package stream_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Limits are built at this width and sliced down by the user.
  localparam int LIM_W = 128;

  function automatic logic [LIM_W-1:0] lim_max(input int w, input bit sgn);
    logic [LIM_W-1:0] v;
    v = '0;
    for (int i = 0; i < LIM_W; i++) begin
      if (i < (sgn ? w - 1 : w)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [LIM_W-1:0] lim_min(input int w, input bit sgn);
    logic [LIM_W-1:0] v;
    v = '0;
    if (sgn) v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/stream_accumulator_addsub.sv
// Combinational add/subtract with overflow detection and optional clamping.
module addsub_sat
  import stream_acc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_y,
  output logic             o_ovf
);

  localparam logic [LIM_W-1:0] MAX_FULL = lim_max(WIDTH, SIGNED);
  localparam logic [LIM_W-1:0] MIN_FULL = lim_min(WIDTH, SIGNED);
  localparam logic [WIDTH-1:0] MAX_V    = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_V    = MIN_FULL[WIDTH-1:0];

  logic [WIDTH:0]   w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_sa;
  logic             w_sb;
  logic             w_sr;
  logic             w_ovf;

  always_comb begin
    w_raw = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
    w_res = w_raw[WIDTH-1:0];
    w_sa  = i_a[WIDTH-1];
    w_sb  = i_b[WIDTH-1];
    w_sr  = w_res[WIDTH-1];
    // Unsigned: the extra bit is the carry on add and the borrow on subtract.
    if (SIGNED) begin
      w_ovf = i_sub ? ((w_sa != w_sb) && (w_sr != w_sa))
                    : ((w_sa == w_sb) && (w_sr != w_sa));
    end else begin
      w_ovf = w_raw[WIDTH];
    end
    o_ovf = w_ovf;
    o_y   = w_res;
    if (SATURATE && w_ovf) begin
      // A signed overflow always runs away in the direction of the accumulator's sign.
      if (SIGNED) o_y = w_sa ? MIN_V : MAX_V;
      else        o_y = i_sub ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/stream_accumulator.sv
// Streaming chain-adder: sums a batch of beats and presents sum/count/overflow on the last one.
module stream_accumulator
  import stream_acc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic [WIDTH-1:0] w_opnd_a;
  logic [WIDTH-1:0] w_y;
  logic             w_beat_ovf;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_accept;
  logic             w_release;

  // A new batch starts from zero rather than whatever the accumulator last held.
  assign w_opnd_a = (r_state == ACCUM) ? r_acc : '0;

  addsub_sat #(
    .WIDTH    (WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_addsub (
    .i_a   (w_opnd_a),
    .i_b   (in_data),
    .i_sub (in_sub),
    .o_y   (w_y),
    .o_ovf (w_beat_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        w_accept = in_valid && !clear;
        if (w_accept) w_state_nxt = in_last ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        w_release = out_ready;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  always_comb begin
    if (r_state == ACCUM) w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;
    else                  w_count_nxt = CNT_ONE;
    w_ovf_nxt = ((r_state == ACCUM) && r_ovf) || w_beat_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear || w_release) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_y;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      if (in_last) begin
        r_out_sum   <= w_y;
        r_out_count <= w_count_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end
    end
  end

  assign out_sum      = r_out_sum;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_stream_accumulator.sv
// Four accumulator configurations driven in lock-step against an arithmetic reference model.
module tb_stream_accumulator;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  always #5 clk = ~clk;

  logic        rdy [ND];
  logic        vld [ND];
  logic        ovf [ND];
  logic [31:0] sum [ND];
  logic [15:0] cnt [ND];
  logic [7:0]  s1, s2, s3;
  logic [15:0] c1, c3;
  logic [1:0]  c2;

  assign sum[1] = {24'd0, s1};
  assign sum[2] = {24'd0, s2};
  assign sum[3] = {24'd0, s3};
  assign cnt[1] = c1;
  assign cnt[2] = {14'd0, c2};
  assign cnt[3] = c3;

  // Configurations: width, signed, saturate, counter width.
  int CW [ND] = '{32, 8, 8, 8};
  bit CS [ND] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit CT [ND] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int CC [ND] = '{16, 16, 2, 16};

  stream_accumulator #(.WIDTH(32), .SIGNED(1'b1), .SATURATE(1'b0), .CNT_W(16)) u_s32w (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last), .out_valid(vld[0]),
    .out_ready(out_ready), .out_sum(sum[0]), .out_count(cnt[0]), .out_overflow(ovf[0]));

  stream_accumulator #(.WIDTH(8), .SIGNED(1'b0), .SATURATE(1'b0), .CNT_W(16)) u_u8w (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data[7:0]), .in_sub(in_sub), .in_last(in_last), .out_valid(vld[1]),
    .out_ready(out_ready), .out_sum(s1), .out_count(c1), .out_overflow(ovf[1]));

  stream_accumulator #(.WIDTH(8), .SIGNED(1'b0), .SATURATE(1'b1), .CNT_W(2)) u_u8s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data[7:0]), .in_sub(in_sub), .in_last(in_last), .out_valid(vld[2]),
    .out_ready(out_ready), .out_sum(s2), .out_count(c2), .out_overflow(ovf[2]));

  stream_accumulator #(.WIDTH(8), .SIGNED(1'b1), .SATURATE(1'b1), .CNT_W(16)) u_s8s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_data(in_data[7:0]), .in_sub(in_sub), .in_last(in_last), .out_valid(vld[3]),
    .out_ready(out_ready), .out_sum(s3), .out_count(c3), .out_overflow(ovf[3]));

  int     n_assert = 0;
  int     n_fail = 0;
  longint m_acc [ND];
  longint m_cnt [ND];
  bit     m_ovf [ND];
  bit     m_open = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Mathematical sum, then range-check against the representable interval.
  task automatic model_beat(input int k, input logic [31:0] d, input bit sub);
    longint modv, mx, mn, a, x, r;
    bit o;
    modv = longint'(1) << CW[k];
    x = longint'(d) & (modv - 1);
    if (CS[k]) begin
      mx = modv / 2 - 1;
      mn = -(modv / 2);
      if (x > mx) x = x - modv;
    end else begin
      mx = modv - 1;
      mn = 0;
    end
    a = m_open ? m_acc[k] : 0;
    r = sub ? a - x : a + x;
    o = (r > mx) || (r < mn);
    if (o) begin
      if (CT[k])        r = (r > mx) ? mx : mn;
      else if (r > mx)  r = r - modv;
      else              r = r + modv;
    end
    m_acc[k] = r;
    m_ovf[k] = (m_open ? m_ovf[k] : 1'b0) | o;
    if (!m_open)                                     m_cnt[k] = 1;
    else if (m_cnt[k] < (longint'(1) << CC[k]) - 1)  m_cnt[k] = m_cnt[k] + 1;
  endtask

  task automatic check_result(input string tag);
    longint modv;
    for (int k = 0; k < ND; k++) begin
      modv = longint'(1) << CW[k];
      check($sformatf("%s_vld%0d", tag, k), 64'(vld[k]), 64'd1);
      check($sformatf("%s_rdy%0d", tag, k), 64'(rdy[k]), 64'd0);
      check($sformatf("%s_sum%0d", tag, k), 64'(sum[k]), 64'(m_acc[k] & (modv - 1)));
      check($sformatf("%s_cnt%0d", tag, k), 64'(cnt[k]), 64'(m_cnt[k]));
      check($sformatf("%s_ovf%0d", tag, k), 64'(ovf[k]), 64'(m_ovf[k]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("%s_vld%0d", tag, k), 64'(vld[k]), 64'd0);
      check($sformatf("%s_sum%0d", tag, k), 64'(sum[k]), 64'd0);
      check($sformatf("%s_cnt%0d", tag, k), 64'(cnt[k]), 64'd0);
      check($sformatf("%s_ovf%0d", tag, k), 64'(ovf[k]), 64'd0);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input bit sub, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("beat_rdy%0d", k), 64'(rdy[k]), 64'd1);
      check($sformatf("beat_vld%0d", k), 64'(vld[k]), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < ND; k++) model_beat(k, d, sub);
    m_open = !last;
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("%s_vld%0d", tag, k), 64'(vld[k]), 64'd0);
      check($sformatf("%s_rdy%0d", tag, k), 64'(rdy[k]), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int bp;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) check($sformatf("rst_rdy%0d", k), 64'(rdy[k]), 64'd1);

    // Signed running sum, one-cycle result latency.
    send_beat(32'd5, 1'b0, 1'b0);
    send_beat(32'd7, 1'b0, 1'b0);
    send_beat(32'hFFFF_FFFD, 1'b0, 1'b1);
    check_result("t1");
    check("t1_sum_s32", 64'(sum[0]), 64'd9);
    check("t1_cnt_s32", 64'(cnt[0]), 64'd3);
    check("t1_ovf_s32", 64'(ovf[0]), 64'd0);
    release_result("t1_rel");

    // Unsigned carry: wrap vs clamp.
    send_beat(32'd200, 1'b0, 1'b0);
    send_beat(32'd100, 1'b0, 1'b1);
    check_result("t2");
    check("t2_sum_u8w", 64'(sum[1]), 64'd44);
    check("t2_ovf_u8w", 64'(ovf[1]), 64'd1);
    check("t2_sum_u8s", 64'(sum[2]), 64'd255);
    check("t2_ovf_u8s", 64'(ovf[2]), 64'd1);
    release_result("t2_rel");

    // Signed clamp then subtract; overflow flag stays set.
    send_beat(32'd100, 1'b0, 1'b0);
    send_beat(32'd100, 1'b0, 1'b0);
    send_beat(32'd50, 1'b1, 1'b1);
    check_result("t3");
    check("t3_sum_s8s", 64'(sum[3]), 64'd77);
    check("t3_ovf_s8s", 64'(ovf[3]), 64'd1);
    release_result("t3_rel");

    // Backpressure in DONE with a competing input beat.
    send_beat(32'd1, 1'b0, 1'b0);
    send_beat(32'd2, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_result("t4_hold");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result("t4_rel");
    send_beat(32'd4, 1'b0, 1'b1);
    check_result("t4_next");
    check("t4_cnt_s32", 64'(cnt[0]), 64'd1);
    check("t4_sum_s32", 64'(sum[0]), 64'd4);
    release_result("t4_rel2");

    // clear mid-batch drops the coincident beat.
    send_beat(32'd10, 1'b0, 1'b0);
    send_beat(32'd20, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd30;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    m_open   = 1'b0;
    send_beat(32'd4, 1'b0, 1'b1);
    check_result("t5");
    check("t5_sum_s32", 64'(sum[0]), 64'd4);
    check("t5_cnt_s32", 64'(cnt[0]), 64'd1);
    // clear while a result is held
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("t5_clr_vld%0d", k), 64'(vld[k]), 64'd0);
      check($sformatf("t5_clr_rdy%0d", k), 64'(rdy[k]), 64'd1);
    end

    // Asynchronous reset in ACCUM and in DONE.
    send_beat(32'd6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst_accum");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_open = 1'b0;
    send_beat(32'd9, 1'b0, 1'b1);
    check_result("t6_pre");
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst_done");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(32'd1, 1'b0, 1'b0);
    send_beat(32'd2, 1'b0, 1'b1);
    check_result("t6");
    check("t6_sum_s32", 64'(sum[0]), 64'd3);
    check("t6_cnt_s32", 64'(cnt[0]), 64'd2);
    release_result("t6_rel");

    // Random batches with random backpressure.
    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        send_beat($urandom, 1'($urandom_range(0, 1)), i == len - 1);
      end
      check_result($sformatf("rnd%0d", b));
      bp = $urandom_range(0, 3);
      repeat (bp) begin
        @(posedge clk);
        #1;
        check_result($sformatf("rnd%0d_bp", b));
      end
      release_result($sformatf("rnd%0d_rel", b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Parametrised streaming chain-adder; the synthesizable successor to file-driven running-sum checks of the ALU add path.
- Accepts a batch of operands over a valid/ready input stream and adds or subtracts each into a running sum.
- On the beat flagged last, it presents the final sum, beat count and sticky overflow on a valid/ready output stream.
- Sits between a data source (DMA/testbench driver) and a result consumer in the datapath test fabric.

Parameters:
- WIDTH, 32, operand/sum width in bits (>=2).
- SIGNED, 1, 1 = two's-complement arithmetic and overflow rules; 0 = unsigned.
- SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH.
- CNT_W, 16, width of beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort/flush of current batch.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  operand.
- in_sub  in  1  0 = acc+in_data, 1 = acc-in_data.
- in_last  in  1  final beat of batch.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  final sum.
- out_count  out  CNT_W  beats accepted in batch.
- out_overflow  out  1  sticky: any beat in batch overflowed.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state IDLE, acc=0, count=0, ovf=0; out_valid=0, out_sum=0, out_count=0, out_overflow=0; in_ready=1 once rst_n high.
- Beat accepted when in_valid && in_ready on a rising edge.
- States: IDLE (no batch open), ACCUM (batch open), DONE (result held).
- in_ready = 1 in IDLE and ACCUM, 0 in DONE (combinational from state only; never from in_valid).
- IDLE + beat: acc <= 0 op in_data, count <= 1, ovf <= beat overflow; -> DONE if in_last else ACCUM.
- ACCUM + beat: acc <= acc op in_data, count <= count+1 (saturates at 2^CNT_W-1, no wrap), ovf <= ovf | beat overflow; -> DONE if in_last.
- DONE: out_valid=1; out_sum/out_count/out_overflow stable while out_valid && !out_ready. On out_valid && out_ready -> IDLE, acc/count/ovf cleared.
- Latency: result valid the cycle after the last beat is accepted; a new batch's first beat can be accepted the cycle after the result handshake (one bubble).
- Overflow, SIGNED=1: add overflows when operand signs match and the result sign differs; sub overflows when operand signs differ and the result sign differs from acc.
- Overflow, SIGNED=0: add overflows on carry out; sub overflows on borrow (in_data > acc).
- SATURATE=1: on overflow, result clamps to max/min representable (signed 2^(W-1)-1 / -2^(W-1); unsigned 2^W-1 / 0).
- SATURATE=0: result wraps modulo 2^WIDTH. Sticky flag is set in both modes.
- clear: highest priority below reset. Any state -> IDLE next edge; acc/count/ovf zeroed; out_valid drops; a beat presented in the same cycle is discarded (in_ready still reads as per state, but the beat is not accumulated).
- Reset mid-batch or in DONE: all state lost immediately; no partial result emitted.
- in_sub/in_last are sampled only on accepted beats.

Decomposition:
- Package stream_acc_pkg: state enum (IDLE, ACCUM, DONE), helper functions for max/min constants per WIDTH/SIGNED.
- Sub-module: addsub_sat, combinational (a, b, sub) -> (y, ovf) honouring SIGNED/SATURATE. FSM, counter and output registers live in stream_accumulator.

Test Plan:
- WIDTH=32 signed wrap: beats 5, 7, -3(last), all in_sub=0, out_ready=1 -> out_sum=9, out_count=3, out_overflow=0, out_valid 1 cycle after the last beat.
- WIDTH=8 unsigned wrap: 200, 100(last) -> out_sum=44, out_overflow=1; same with SATURATE=1 -> out_sum=255, out_overflow=1.
- WIDTH=8 signed SATURATE=1: 100, 100, in_sub beat 50(last) -> 127 clamp, then 77; out_sum=77, out_overflow=1 (sticky).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> in_ready=0, outputs stable; new-batch in_valid beats not accepted until the handshake completes.
- clear mid-batch after beats 10, 20, asserted together with beat 30 -> beat 30 dropped; next batch 4(last) -> out_sum=4, out_count=1.
- rst_n pulsed low in ACCUM and again in DONE -> outputs read 0 immediately; subsequent batch 1, 2(last) -> out_sum=3, out_count=2.
